// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Shared encodings for the branch resolve unit. This covers the
//               in_op operation codes and the branch funct3 conditions.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    // Operation selected by the execute stage
    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_JAL    = 2'b01,
        OP_JALR   = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    // Conditional-branch funct3 encodings (010 and 011 are reserved)
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

endpackage : branch_resolve_unit_pkg
`default_nettype wire

// File: rtl/branch_resolve_unit_br_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : br_cond_eval
// Description : Combinational branch-condition evaluator. It maps funct3 and
//               two operands to a taken flag, and flags reserved encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module br_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken,
    output logic            illegal
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (a == b);
    assign w_lt_s = ($signed(a) < $signed(b));
    assign w_lt_u = (a < b);

    // Select the comparison result; a reserved encoding is never taken
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            FUNCT3_BEQ:  taken = w_eq;
            FUNCT3_BNE:  taken = !w_eq;
            FUNCT3_BLT:  taken = w_lt_s;
            FUNCT3_BGE:  taken = !w_lt_s;
            FUNCT3_BLTU: taken = w_lt_u;
            FUNCT3_BGEU: taken = !w_lt_u;
            default:     illegal = 1'b1;
        endcase
    end

endmodule : br_cond_eval
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves BRANCH/JAL/JALR in one registered stage. It checks
//               the fetch prediction, produces the redirect PC, and keeps
//               saturating branch and mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16,
    parameter int IALIGN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_illegal,
    output logic             out_misaligned,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam logic [XLEN-1:0]  C_FOUR    = XLEN'(4);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Combinational resolution of the incoming request
    logic            w_cond_taken;
    logic            w_cond_illegal;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_rs1_imm;
    logic [XLEN-1:0] w_link;
    logic            w_taken;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redirect;
    logic            w_mispredict;
    logic            w_align_bit;
    logic            w_accept;
    logic            w_handshake;

    // Pipeline register and counters
    logic             valid_q,      valid_d;
    logic             taken_q,      taken_d;
    logic [XLEN-1:0]  target_q,     target_d;
    logic [XLEN-1:0]  link_q,       link_d;
    logic             mispredict_q, mispredict_d;
    logic [XLEN-1:0]  redirect_q,   redirect_d;
    logic             illegal_q,    illegal_d;
    logic             misaligned_q, misaligned_d;
    logic [CNT_W-1:0] branches_q,   branches_d;
    logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

    br_cond_eval #(
        .XLEN    (XLEN)
    ) u_cond (
        .funct3  (in_funct3),
        .a       (in_rs1),
        .b       (in_rs2),
        .taken   (w_cond_taken),
        .illegal (w_cond_illegal)
    );

    assign w_pc_imm  = in_pc + in_imm;
    assign w_rs1_imm = in_rs1 + in_imm;
    assign w_link    = in_pc + C_FOUR;

    // Direction, target and legality per operation class
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_target  = w_pc_imm;
        case (op_e'(in_op))
            OP_BRANCH: begin
                w_taken   = w_cond_taken;
                w_illegal = w_cond_illegal;
            end
            OP_JAL: begin
                w_taken = 1'b1;
            end
            OP_JALR: begin
                w_taken  = 1'b1;
                w_target = {w_rs1_imm[XLEN-1:1], 1'b0};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_redirect   = w_taken ? w_target : w_link;
    assign w_mispredict = (w_taken != in_pred_taken) ||
                          (w_taken && in_pred_taken && (w_target != in_pred_target));

    // Compressed-capable cores (IALIGN 16) never flag a halfword target
    generate
        if (IALIGN == 32) begin : g_align_chk
            assign w_align_bit = w_target[1];
        end else begin : g_align_none
            assign w_align_bit = 1'b0;
        end
    endgenerate

    assign in_ready    = !valid_q || out_ready;
    assign w_accept    = in_valid && in_ready && !flush;
    // A result killed by flush in the same cycle is not counted as consumed
    assign w_handshake = valid_q && out_ready && !flush;

    // Next state of the output register: flush, then load, then drain
    always_comb begin
        valid_d      = valid_q;
        taken_d      = taken_q;
        target_d     = target_q;
        link_d       = link_q;
        mispredict_d = mispredict_q;
        redirect_d   = redirect_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d      = 1'b1;
            taken_d      = w_taken;
            target_d     = w_target;
            link_d       = w_link;
            mispredict_d = w_mispredict;
            redirect_d   = w_redirect;
            illegal_d    = w_illegal;
            misaligned_d = w_taken && w_align_bit;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Saturating statistics counters; clear wins over increment
    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (stat_clr) begin
            branches_d    = '0;
            mispredicts_d = '0;
        end else if (w_handshake) begin
            if (branches_q != C_CNT_MAX) begin
                branches_d = branches_q + 1'b1;
            end
            if (mispredict_q && (mispredicts_q != C_CNT_MAX)) begin
                mispredicts_d = mispredicts_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            taken_q       <= 1'b0;
            target_q      <= '0;
            link_q        <= '0;
            mispredict_q  <= 1'b0;
            redirect_q    <= '0;
            illegal_q     <= 1'b0;
            misaligned_q  <= 1'b0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            valid_q       <= valid_d;
            taken_q       <= taken_d;
            target_q      <= target_d;
            link_q        <= link_d;
            mispredict_q  <= mispredict_d;
            redirect_q    <= redirect_d;
            illegal_q     <= illegal_d;
            misaligned_q  <= misaligned_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_taken        = taken_q;
    assign out_target       = target_q;
    assign out_link         = link_q;
    assign out_mispredict   = mispredict_q;
    assign out_redirect_pc  = redirect_q;
    assign out_illegal      = illegal_q;
    assign out_misaligned   = misaligned_q;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule : branch_resolve_unit
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit. A second
//               instance with 2-bit counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic [1:0]      in_op = 2'b00;
    logic [2:0]      in_funct3 = 3'b000;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic            in_pred_taken = 1'b0;
    logic [XLEN-1:0] in_pred_target = '0;
    logic            out_ready = 1'b1;
    logic            stat_clr = 1'b0;

    logic            in_ready, out_valid, out_taken, out_mispredict;
    logic            out_illegal, out_misaligned;
    logic [XLEN-1:0] out_target, out_link, out_redirect_pc;
    logic [15:0]     stat_branches, stat_mispredicts;

    logic            s_in_ready, s_out_valid, s_out_taken, s_out_mispredict;
    logic            s_out_illegal, s_out_misaligned;
    logic [XLEN-1:0] s_out_target, s_out_link, s_out_redirect_pc;
    logic [1:0]      s_stat_branches, s_stat_mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(16), .IALIGN(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_taken(out_taken), .out_target(out_target),
        .out_link(out_link), .out_mispredict(out_mispredict),
        .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
        .out_misaligned(out_misaligned), .stat_clr(stat_clr),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(2), .IALIGN(32)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
        .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_taken(s_out_taken), .out_target(s_out_target),
        .out_link(s_out_link), .out_mispredict(s_out_mispredict),
        .out_redirect_pc(s_out_redirect_pc), .out_illegal(s_out_illegal),
        .out_misaligned(s_out_misaligned), .stat_clr(stat_clr),
        .stat_branches(s_stat_branches), .stat_mispredicts(s_stat_mispredicts)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptgt);
        in_valid       = 1'b1;
        in_op          = op;
        in_funct3      = f3;
        in_pc          = pc;
        in_rs1         = rs1;
        in_rs2         = rs2;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("rst_valid",   out_valid, 0);
        chk("rst_target",  out_target, 0);
        chk("rst_redir",   out_redirect_pc, 0);
        chk("rst_br_cnt",  stat_branches, 0);
        chk("rst_mp_cnt",  stat_mispredicts, 0);
        chk("rst_ready",   in_ready, 1);
        rst = 1'b0;
        step();

        // BEQ taken, predicted not-taken
        present(2'b00, 3'b000, 32'h100, 32'h5, 32'h5, 32'h20, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("beq_valid",  out_valid, 1);
        chk("beq_taken",  out_taken, 1);
        chk("beq_target", out_target, 32'h120);
        chk("beq_mp",     out_mispredict, 1);
        chk("beq_redir",  out_redirect_pc, 32'h120);
        chk("beq_link",   out_link, 32'h104);
        step();
        chk("beq_drain",  out_valid, 0);
        chk("beq_br_cnt", stat_branches, 1);
        chk("beq_mp_cnt", stat_mispredicts, 1);

        // Signed versus unsigned less-than, correctly predicted
        present(2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h8, 1'b1, 32'h208);
        step();
        chk("blt_taken",  out_taken, 1);
        chk("blt_target", out_target, 32'h208);
        chk("blt_mp",     out_mispredict, 0);
        present(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h8, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("bltu_taken", out_taken, 0);
        chk("bltu_mp",    out_mispredict, 0);
        chk("bltu_redir", out_redirect_pc, 32'h204);
        chk("b2b_br_cnt", stat_branches, 2);
        step();
        chk("sign_br_cnt", stat_branches, 3);
        chk("sign_mp_cnt", stat_mispredicts, 1);

        // JALR clears bit 0; target has bit 1 set
        present(2'b10, 3'b000, 32'h300, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1006);
        step();
        chk("jalr_target", out_target, 32'h1006);
        chk("jalr_taken",  out_taken, 1);
        chk("jalr_mp",     out_mispredict, 0);
        chk("jalr_mis",    out_misaligned, 1);
        chk("jalr_link",   out_link, 32'h304);

        // Backpressure with a pending JAL
        out_ready = 1'b0;
        present(2'b01, 3'b000, 32'h400, 32'h0, 32'h0, 32'h40, 1'b1, 32'h440);
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid",  out_valid, 1);
            chk("bp_target", out_target, 32'h1006);
            chk("bp_br_cnt", stat_branches, 3);
        end
        out_ready = 1'b1;
        step();
        chk("jal_target", out_target, 32'h440);
        chk("jal_link",   out_link, 32'h404);
        chk("jal_mis",    out_misaligned, 0);
        chk("jal_br_cnt", stat_branches, 4);
        present(2'b00, 3'b001, 32'h500, 32'h1, 32'h2, 32'h10, 1'b0, 32'h0);
        step();
        chk("bne_target", out_target, 32'h510);
        chk("bne_mp",     out_mispredict, 1);
        chk("bne_br_cnt", stat_branches, 5);
        chk("bne_mp_cnt", stat_mispredicts, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        chk("hold_valid", out_valid, 1);

        // Flush kills held result and drops the same-cycle input
        flush = 1'b1;
        present(2'b00, 3'b000, 32'h600, 32'h1, 32'h1, 32'h8, 1'b0, 32'h0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("fl_valid",  out_valid, 0);
        chk("fl_br_cnt", stat_branches, 5);
        chk("fl_mp_cnt", stat_mispredicts, 1);
        step();
        chk("fl_dropped", out_valid, 0);
        chk("fl_br_cnt2", stat_branches, 5);

        // Reserved funct3
        present(2'b00, 3'b010, 32'h700, 32'h0, 32'h0, 32'hC, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("ill_flag",  out_illegal, 1);
        chk("ill_taken", out_taken, 0);
        chk("ill_redir", out_redirect_pc, 32'h704);
        chk("ill_mp",    out_mispredict, 0);
        step();
        chk("ill_br_cnt", stat_branches, 6);

        // Reserved op
        present(2'b11, 3'b000, 32'h800, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("rsv_flag",   out_illegal, 1);
        chk("rsv_taken",  out_taken, 0);
        chk("rsv_target", out_target, 32'h810);
        step();

        // Saturation: five mispredicted handshakes
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_br_cnt", stat_branches, 0);
        chk("clr_sat",    s_stat_branches, 0);
        for (int i = 0; i < 5; i++) begin
            present(2'b00, 3'b000, 32'h900, 32'h3, 32'h3, 32'h4, 1'b0, 32'h0);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("sat_big_br", stat_branches, 5);
        chk("sat_big_mp", stat_mispredicts, 5);
        chk("sat_br",     s_stat_branches, 3);
        chk("sat_mp",     s_stat_mispredicts, 3);

        // Clear coinciding with a handshake
        present(2'b01, 3'b000, 32'hA00, 32'h0, 32'h0, 32'h8, 1'b1, 32'hA08);
        step();
        in_valid = 1'b0;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_hs_br", stat_branches, 0);
        chk("clr_hs_mp", stat_mispredicts, 0);

        // Asynchronous reset while a result is held
        present(2'b01, 3'b000, 32'hB00, 32'h0, 32'h0, 32'h8, 1'b1, 32'hB08);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("ar_pre_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid",  out_valid, 0);
        chk("ar_target", out_target, 0);
        chk("ar_br_cnt", stat_branches, 0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ar_after", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_resolve_unit
`default_nettype wire
